// File: rtl/mat_mult_arb_pkg.sv
// Shared types and constants for the mat_mult_arb multiplier arbiter.
// Round-robin arbitration is enabled by defining MAT_MULT_ARB_RR_EN.
package mat_mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } mm_arb_state_t;

  localparam int OPC_W = 16;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mm_arb_pick.sv
// Combinational grant picker: round-robin after i_ptr when
// MAT_MULT_ARB_RR_EN is defined, otherwise lowest index wins.
module mm_arb_pick
  import mat_mult_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

`ifdef MAT_MULT_ARB_RR_EN
  logic [NUM_REQ-1:0] w_rot;
  int                 w_off;

  // Rotate so bit 0 is the requester just after the pointer.
  always_comb begin
    w_rot = NUM_REQ'({i_valid, i_valid} >> (int'(i_ptr) + 1));
    o_any = 1'b0;
    w_off = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!o_any && w_rot[j]) begin
        o_any = 1'b1;
        w_off = int'(i_ptr) + 1 + j;
      end
    end
    if (w_off >= NUM_REQ) w_off = w_off - NUM_REQ;
    o_idx   = ID_W'(w_off);
    o_grant = o_any ? (NUM_REQ'(1) << w_off) : '0;
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  always_comb begin
    o_idx = '0;
    o_any = |i_valid;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (i_valid[j]) o_idx = ID_W'(j);
    end
    o_grant = o_any ? (NUM_REQ'(1) << o_idx) : '0;
  end
`endif

endmodule

// File: rtl/mat_mult_arb.sv
// Shares one registered GF(2) MAT_MULT between NUM_REQ requesters.
// Define MAT_MULT_ARB_RR_EN for round-robin, else fixed priority.
module mat_mult_arb
  import mat_mult_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int A_ROWS  = 4,
  parameter  int A_COLS  = 8,
  parameter  int B_COLS  = 1,
  localparam int ID_W    = id_w(NUM_REQ),
  localparam int AW      = A_ROWS * A_COLS,
  localparam int BW      = A_COLS * B_COLS,
  localparam int CW      = A_ROWS * B_COLS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*AW-1:0] req_a,
  input  logic [NUM_REQ*BW-1:0] req_b,
  output logic                  mm_rst,
  output logic [AW-1:0]         mm_a,
  output logic [BW-1:0]         mm_b,
  input  logic [CW-1:0]         mm_c,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [CW-1:0]         rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  busy,
  output logic [OPC_W-1:0]      op_count
);

  mm_arb_state_t      r_state;
  mm_arb_state_t      w_next;
  logic [AW-1:0]      r_a;
  logic [BW-1:0]      r_b;
  logic [ID_W-1:0]    r_id;
  logic [CW-1:0]      r_data;
  logic [OPC_W-1:0]   r_op_cnt;
  logic               r_mm_rst;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_idx;
  logic [ID_W-1:0]    w_ptr;
  logic               w_any;
  logic               w_accept;
  logic               w_done;

`ifdef MAT_MULT_ARB_RR_EN
  logic [ID_W-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ptr <= ID_W'(NUM_REQ - 1);
    else if (w_accept) r_ptr <= w_idx;
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  mm_arb_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .i_valid(req_valid),
    .i_ptr  (w_ptr),
    .o_grant(w_grant),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  // No accepts while the multiplier is still held in reset.
  assign w_accept  = (r_state == IDLE) && !r_mm_rst && w_any;
  assign w_done    = (r_state == RESP) && rsp_ready;
  assign req_ready = w_accept ? w_grant : '0;

  assign mm_rst    = r_mm_rst;
  assign mm_a      = r_a;
  assign mm_b      = r_b;
  assign rsp_valid = (r_state == RESP);
  assign rsp_data  = r_data;
  assign rsp_id    = r_id;
  assign busy      = (r_state != IDLE);
  assign op_count  = r_op_cnt;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = ISSUE;
      ISSUE:   w_next = CAPTURE;
      CAPTURE: w_next = RESP;
      RESP:    if (w_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_mm_rst <= 1'b1;
    else r_mm_rst <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a  <= '0;
      r_b  <= '0;
      r_id <= '0;
    end else if (w_accept) begin
      r_a  <= req_a[w_idx*AW +: AW];
      r_b  <= req_b[w_idx*BW +: BW];
      r_id <= w_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_data <= '0;
    else if (r_state == CAPTURE) r_data <= mm_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_op_cnt <= '0;
    else if (w_done && (r_op_cnt != '1)) r_op_cnt <= r_op_cnt + 1'b1;
  end

endmodule

// File: doc/mat_mult_arb.md
# mat_mult_arb

Arbiter and sequencer that shares one registered GF(2) matrix-vector multiplier (`MAT_MULT`) between `NUM_REQ` requesters. It accepts one operand pair at a time through a valid/ready handshake, drives the multiplier, captures its one-cycle-latency result, and returns it with the requester ID. It sits between the requesting blocks and a single `MAT_MULT` instance and is the only driver of that instance's inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `A_ROWS`, 4: matrix rows, equal to the multiplier's `A_ROWS`.
- `A_COLS`, 8: matrix columns, equal to the multiplier's `A_COLS`.
- `B_COLS`, 1: vector columns, equal to the multiplier's `B_COLS`.

Ports:
- `clk`  in  1  clock; all logic is clocked on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_ready`  out  NUM_REQ  one-hot accept pulse.
- `req_a`  in  NUM_REQ×(A_ROWS*A_COLS)  packed A operands; requester i occupies slice i.
- `req_b`  in  NUM_REQ×(A_COLS*B_COLS)  packed B operands.
- `mm_rst`  out  1  active-high synchronous reset to the multiplier.
- `mm_a`  out  A_ROWS*A_COLS  A operand to the multiplier.
- `mm_b`  out  A_COLS*B_COLS  B operand to the multiplier.
- `mm_c`  in  A_ROWS*B_COLS  multiplier result.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_data`  out  A_ROWS*B_COLS  result.
- `rsp_id`  out  $clog2(NUM_REQ)  index of the requester that owns the result.
- `busy`  out  1  high in every state except IDLE.
- `op_count`  out  16  count of completed operations; saturates at 0xFFFF.

## Operation
- FSM states:
  - **IDLE**: arbitrate among `req_valid`. On a grant, pulse `req_ready[g]`, latch `req_a[g]`, `req_b[g]` and `g` into operand and ID registers, then go to ISSUE. With no request, stay in IDLE.
  - **ISSUE**: `mm_a`/`mm_b` present the latched operands. The multiplier registers them at the end of this cycle. Go to CAPTURE.
  - **CAPTURE**: latch `mm_c` into `rsp_data`. Go to RESP.
  - **RESP**: `rsp_valid`=1. When `rsp_ready`=1, increment `op_count` and go to IDLE. Otherwise hold the state and `rsp_data`/`rsp_id`.
- `mm_a`/`mm_b` are driven continuously from the operand registers and are stable from ISSUE through RESP.
- Requesters may drop or change operands after their `req_ready` pulse.
- Arbitration takes place only in IDLE. At most one `req_ready` bit is high in any cycle.
- Requests that arrive while busy wait. `req_valid` must be held until accepted.
- `mm_rst`=1 while `rst` is low and during the first clock after deassertion, then 0.

## Timing
- Reset values: state=IDLE, `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, operand registers=0, `busy`=0, `op_count`=0, round-robin pointer=NUM_REQ-1, `mm_rst`=1.
- Latency from the accept cycle (`req_ready` high) to `rsp_valid` high is 3 cycles.
- Minimum spacing between accepts is 4 cycles, when `rsp_ready` is tied high.
- If `rst` is asserted mid-operation, the in-flight result is discarded and `op_count` is not incremented.
- `req_valid` and `rsp_ready` are sampled only in IDLE and RESP respectively; their values in other states are ignored.
- When `op_count`=0xFFFF and another operation completes, `op_count` stays at 0xFFFF.

## Configuration
- `MAT_MULT_ARB_RR_EN` defined:
  - Round-robin arbitration. Search starts at index pointer+1 and wraps modulo NUM_REQ.
  - The pointer updates to the granted index on each accept.
- `MAT_MULT_ARB_RR_EN` undefined:
  - Fixed priority; the lowest index wins.
  - The pointer register is not present.

## Structure
- Package `mat_mult_arb_pkg` holds:
  - the state enum `mm_arb_state_t` (IDLE, ISSUE, CAPTURE, RESP);
  - `ID_W = $clog2(NUM_REQ)` helper;
  - the `op_count` width constant 16.
- Sub-module `mm_arb_pick`: combinational grant selection. Inputs are `req_valid` and the pointer; outputs are a one-hot grant and the encoded index. It contains the `MAT_MULT_ARB_RR_EN` switch.
- The FSM, operand/result registers and counter live in the top module.

## Test plan
1. Single request, with `MAT_MULT` attached:
   - stimulus: requester 2, A rows (row 0 at LSB) = 0xFF, 0x0F, 0x01, 0x00; B=0x03; `rsp_ready`=1.
   - response: `req_ready`=4'b0100 in one cycle; 3 cycles later `rsp_valid`=1, `rsp_data`=4'b0100, `rsp_id`=2; `op_count`=1.
2. All four requesters valid simultaneously, `MAT_MULT_ARB_RR_EN` defined:
   - response: grant order 0,1,2,3,0, each 4 cycles apart.
   - without the macro: grants go only to 0 while it stays valid.
3. Backpressure:
   - stimulus: `rsp_ready`=0 for 10 cycles after `rsp_valid`.
   - response: `rsp_data`/`rsp_id` stable; no `req_ready` pulses; `busy`=1; completion happens on the first cycle with `rsp_ready`=1.
4. Reset asserted in CAPTURE:
   - response: all outputs return to their reset values asynchronously; `op_count` unchanged from its pre-operation value of 0; `mm_rst`=1 for one clock after release.
5. Operand independence:
   - stimulus: requester changes `req_a` to all-ones the cycle after its `req_ready`.
   - response: `rsp_data` reflects the originally accepted operands.
6. Saturation:
   - stimulus: force `op_count` to 0xFFFE, then complete 2 operations.
   - response: `op_count` reads 0xFFFF after both.
